// File: rtl/irq_pkg.sv
// Shared types and constants for the hart-side interrupt controller.
package irq_pkg;

    // Controller sequence: arbitrate, request trap, run handler, notify PLIC.
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHandler,
        StComplete
    } irq_state_e;

    // Interrupt class latched when the request is raised.
    typedef enum logic [1:0] {
        ClsNone,
        ClsExt,
        ClsSw,
        ClsTmr
    } irq_class_e;

    // Machine interrupt exception codes.
    localparam logic [4:0] MEI_CODE = 5'd11;
    localparam logic [4:0] MSI_CODE = 5'd3;
    localparam logic [4:0] MTI_CODE = 5'd7;

    // Widest supported XLEN; callers truncate the result to their own XLEN.
    localparam int unsigned MAX_XLEN = 64;

    // Build an interrupt mcause value: bit xlen-1 set, code in the low bits.
    function automatic logic [MAX_XLEN-1:0] irq_mcause(input logic [4:0]  code,
                                                       input int unsigned xlen);
        logic [MAX_XLEN-1:0] c;
        c = {{(MAX_XLEN-5){1'b0}}, code};
        c = c | ({{(MAX_XLEN-1){1'b0}}, 1'b1} << (xlen - 1));
        return c;
    endfunction

endpackage

// File: rtl/irq_hart_ctrl.sv
// Hart-side interrupt controller: arbitrates machine interrupts, holds the trap
// request, captures the PLIC claim ID and strobes completion after MRET.
module irq_hart_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned SRC_ID_WIDTH = 5,
    parameter int unsigned XLEN         = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ext_irq_i,
    input  logic [SRC_ID_WIDTH-1:0] claim_id_i,
    input  logic                    timer_irq_i,
    input  logic                    soft_irq_i,
    input  logic                    mstatus_mie_i,
    input  logic [2:0]              mie_i,
    input  logic                    trap_ack_i,
    input  logic                    mret_i,
    output logic                    trap_req_o,
    output logic [XLEN-1:0]         trap_cause_o,
    output logic [SRC_ID_WIDTH-1:0] claim_id_o,
    output logic                    complete_o,
    output logic                    busy_o
);

    irq_state_e              state_q, state_d;
    irq_class_e              cls_q, cls_d;
    logic [XLEN-1:0]         cause_q, cause_d;
    logic [SRC_ID_WIDTH-1:0] claim_q, claim_d;
    logic                    req_q, complete_q, busy_q;

    logic       ext_elig, sw_elig, tmr_elig;
    irq_class_e win_cls;
    logic [4:0] win_code;

    assign ext_elig = mstatus_mie_i & ext_irq_i   & mie_i[2];
    assign tmr_elig = mstatus_mie_i & timer_irq_i & mie_i[1];
    assign sw_elig  = mstatus_mie_i & soft_irq_i  & mie_i[0];

    // Fixed-priority pick: EXT > SW > TMR.
    always_comb begin
        win_cls  = ClsNone;
        win_code = '0;
        if (ext_elig) begin
            win_cls  = ClsExt;
            win_code = MEI_CODE;
        end else if (sw_elig) begin
            win_cls  = ClsSw;
            win_code = MSI_CODE;
        end else if (tmr_elig) begin
            win_cls  = ClsTmr;
            win_code = MTI_CODE;
        end
    end

    // Next-state logic; arbitration only happens in StIdle, so an in-flight
    // request is never withdrawn or re-arbitrated.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cause_d = cause_q;
        claim_d = claim_q;
        unique case (state_q)
            StIdle: begin
                if (win_cls != ClsNone) begin
                    state_d = StReq;
                    cls_d   = win_cls;
                    cause_d = XLEN'(irq_mcause(win_code, XLEN));
                end
            end
            StReq: begin
                if (trap_ack_i) begin
                    state_d = StHandler;
                    if (cls_q == ClsExt) begin
                        claim_d = claim_id_i;
                    end
                end
            end
            StHandler: begin
                if (mret_i) begin
                    if (cls_q == ClsExt) begin
                        state_d = StComplete;
                    end else begin
                        state_d = StIdle;
                        cls_d   = ClsNone;
                    end
                end
            end
            StComplete: begin
                state_d = StIdle;
                cls_d   = ClsNone;
            end
            default: begin
                state_d = StIdle;
                cls_d   = ClsNone;
            end
        endcase
    end

    // State and registered outputs; outputs are derived from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cls_q      <= ClsNone;
            cause_q    <= '0;
            claim_q    <= '0;
            req_q      <= 1'b0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            cause_q    <= cause_d;
            claim_q    <= claim_d;
            req_q      <= (state_d == StReq);
            complete_q <= (state_d == StComplete);
            busy_q     <= (state_d != StIdle);
        end
    end

    assign trap_req_o   = req_q;
    assign trap_cause_o = cause_q;
    assign claim_id_o   = claim_q;
    assign complete_o   = complete_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_irq_hart_ctrl.sv
// Self-checking bench for irq_hart_ctrl: vector table plus hand sequences,
// with expected outputs queued at drive time and compared one cycle later.
module tb_irq_hart_ctrl;

    localparam int unsigned SW = 5;
    localparam int unsigned XL = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          ext_irq_i, timer_irq_i, soft_irq_i, mstatus_mie_i;
    logic [SW-1:0] claim_id_i;
    logic [2:0]    mie_i;
    logic          trap_ack_i, mret_i;
    logic          trap_req_o, complete_o, busy_o;
    logic [XL-1:0] trap_cause_o;
    logic [SW-1:0] claim_id_o;

    irq_hart_ctrl #(.SRC_ID_WIDTH(SW), .XLEN(XL)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .ext_irq_i     (ext_irq_i),
        .claim_id_i    (claim_id_i),
        .timer_irq_i   (timer_irq_i),
        .soft_irq_i    (soft_irq_i),
        .mstatus_mie_i (mstatus_mie_i),
        .mie_i         (mie_i),
        .trap_ack_i    (trap_ack_i),
        .mret_i        (mret_i),
        .trap_req_o    (trap_req_o),
        .trap_cause_o  (trap_cause_o),
        .claim_id_o    (claim_id_o),
        .complete_o    (complete_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          ext, tmr, sw, gie;
        logic [2:0]    mie;
        logic          ack, mret;
        logic [SW-1:0] cid;
        logic          req;
        logic [XL-1:0] cause;
        logic [SW-1:0] claim;
        logic          comp, busy;
    } vec_t;

    vec_t   sb_q[$];
    vec_t   tbl[29];
    int     checks = 0;
    int     errors = 0;
    string  tag;

    localparam logic [XL-1:0] C_EXT = 32'h8000_000B;
    localparam logic [XL-1:0] C_SW  = 32'h8000_0003;
    localparam logic [XL-1:0] C_TMR = 32'h8000_0007;

    function automatic vec_t mk(input logic ext, input logic tmr, input logic sw,
                                input logic gie, input logic [2:0] mie, input logic ack,
                                input logic mret, input logic [SW-1:0] cid,
                                input logic req, input logic [XL-1:0] cause,
                                input logic [SW-1:0] claim, input logic comp,
                                input logic busy);
        vec_t v;
        v.ext = ext;  v.tmr = tmr;  v.sw = sw;  v.gie = gie;  v.mie = mie;
        v.ack = ack;  v.mret = mret;  v.cid = cid;
        v.req = req;  v.cause = cause;  v.claim = claim;  v.comp = comp;  v.busy = busy;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic cyc(input vec_t v);
        vec_t e;
        ext_irq_i     = v.ext;
        timer_irq_i   = v.tmr;
        soft_irq_i    = v.sw;
        mstatus_mie_i = v.gie;
        mie_i         = v.mie;
        trap_ack_i    = v.ack;
        mret_i        = v.mret;
        claim_id_i    = v.cid;
        sb_q.push_back(v);
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            cmp({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            cmp({tag, " trap_req"}, 32'(trap_req_o), 32'(e.req));
            if (e.req) cmp({tag, " trap_cause"}, trap_cause_o, e.cause);
            cmp({tag, " claim_id"}, 32'(claim_id_o), 32'(e.claim));
            cmp({tag, " complete"}, 32'(complete_o), 32'(e.comp));
            cmp({tag, " busy"}, 32'(busy_o), 32'(e.busy));
        end
    endtask

    task automatic chk_zero(input string name);
        cmp({name, " trap_req"}, 32'(trap_req_o), 32'd0);
        cmp({name, " trap_cause"}, trap_cause_o, 32'd0);
        cmp({name, " claim_id"}, 32'(claim_id_o), 32'd0);
        cmp({name, " complete"}, 32'(complete_o), 32'd0);
        cmp({name, " busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        // ext tmr sw gie mie ack mret cid | req cause claim comp busy
        tbl[0]  = mk(0, 0, 0, 1, 3'b111, 0, 0, 0,  0, 0,     0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 1, 3'b111, 0, 0, 5,  1, C_EXT, 0, 0, 1);
        tbl[2]  = mk(1, 0, 0, 1, 3'b111, 0, 0, 5,  1, C_EXT, 0, 0, 1);
        tbl[3]  = mk(0, 0, 0, 1, 3'b111, 1, 0, 5,  0, 0,     5, 0, 1);
        tbl[4]  = mk(0, 0, 0, 1, 3'b111, 0, 0, 0,  0, 0,     5, 0, 1);
        tbl[5]  = mk(0, 0, 0, 1, 3'b111, 0, 1, 0,  0, 0,     5, 1, 1);
        tbl[6]  = mk(0, 0, 0, 1, 3'b111, 0, 0, 0,  0, 0,     5, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 3'b111, 0, 0, 0,  0, 0,     5, 0, 0);
        tbl[8]  = mk(1, 1, 1, 1, 3'b111, 0, 0, 9,  1, C_EXT, 5, 0, 1);
        tbl[9]  = mk(0, 1, 1, 1, 3'b111, 1, 0, 9,  0, 0,     9, 0, 1);
        tbl[10] = mk(0, 1, 1, 1, 3'b111, 0, 1, 0,  0, 0,     9, 1, 1);
        tbl[11] = mk(0, 1, 1, 1, 3'b111, 0, 0, 0,  0, 0,     9, 0, 0);
        tbl[12] = mk(0, 1, 1, 1, 3'b111, 0, 0, 0,  1, C_SW,  9, 0, 1);
        tbl[13] = mk(0, 1, 1, 1, 3'b111, 1, 0, 7,  0, 0,     9, 0, 1);
        tbl[14] = mk(0, 1, 0, 1, 3'b111, 0, 1, 0,  0, 0,     9, 0, 0);
        tbl[15] = mk(0, 1, 0, 1, 3'b111, 0, 0, 0,  1, C_TMR, 9, 0, 1);
        tbl[16] = mk(0, 0, 0, 1, 3'b111, 0, 0, 0,  1, C_TMR, 9, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0,  1, C_TMR, 9, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 3'b000, 1, 0, 0,  0, 0,     9, 0, 1);
        tbl[19] = mk(0, 0, 0, 0, 3'b000, 0, 1, 0,  0, 0,     9, 0, 0);
        tbl[20] = mk(1, 1, 1, 0, 3'b111, 0, 0, 0,  0, 0,     9, 0, 0);
        tbl[21] = mk(1, 1, 1, 0, 3'b111, 1, 0, 0,  0, 0,     9, 0, 0);
        tbl[22] = mk(1, 1, 1, 0, 3'b111, 0, 1, 0,  0, 0,     9, 0, 0);
        tbl[23] = mk(0, 1, 0, 1, 3'b111, 0, 0, 0,  1, C_TMR, 9, 0, 1);
        tbl[24] = mk(1, 1, 0, 1, 3'b111, 0, 0, 3,  1, C_TMR, 9, 0, 1);
        tbl[25] = mk(1, 1, 0, 1, 3'b111, 1, 0, 3,  0, 0,     9, 0, 1);
        tbl[26] = mk(0, 0, 0, 1, 3'b111, 0, 1, 0,  0, 0,     9, 0, 0);
        tbl[27] = mk(1, 0, 0, 1, 3'b011, 0, 0, 4,  0, 0,     9, 0, 0);
        tbl[28] = mk(0, 0, 0, 1, 3'b111, 0, 0, 0,  0, 0,     9, 0, 0);

        rst_ni = 1'b0;
        ext_irq_i = 0; timer_irq_i = 0; soft_irq_i = 0; mstatus_mie_i = 0;
        mie_i = '0; trap_ack_i = 0; mret_i = 0; claim_id_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_zero("in_reset");
        rst_ni = 1'b1;
        chk_zero("after_reset");

        for (int i = 0; i < 29; i++) begin
            tag = $sformatf("vec%0d", i);
            cyc(tbl[i]);
        end

        // Global enable low with every source pending: nothing for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tag = $sformatf("gie_off%0d", i);
            cyc(mk(1, 1, 1, 0, 3'b111, 0, 0, 0,  0, 0, 9, 0, 0));
        end
        // Raising the global enable requests one cycle later; spurious claim 0.
        tag = "gie_on";
        cyc(mk(1, 1, 1, 1, 3'b111, 0, 0, 0,  1, C_EXT, 9, 0, 1));
        tag = "spur_ack";
        cyc(mk(0, 0, 0, 1, 3'b111, 1, 0, 0,  0, 0, 0, 0, 1));
        tag = "spur_mret";
        cyc(mk(0, 0, 0, 1, 3'b111, 0, 1, 0,  0, 0, 0, 1, 1));
        tag = "spur_done";
        cyc(mk(0, 0, 0, 1, 3'b111, 0, 0, 0,  0, 0, 0, 0, 0));

        // Reset while in the handler of an external claim: no completion ever.
        tag = "rst_req";
        cyc(mk(1, 0, 0, 1, 3'b111, 0, 0, 12, 1, C_EXT, 0, 0, 1));
        tag = "rst_ack";
        cyc(mk(0, 0, 0, 1, 3'b111, 1, 0, 12, 0, 0, 12, 0, 1));
        trap_ack_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk_zero("async_reset");
        mret_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk_zero("held_reset");
        rst_ni = 1'b1;
        tag = "post_rst_mret";
        cyc(mk(0, 0, 0, 1, 3'b111, 0, 1, 0,  0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tag = $sformatf("post_rst%0d", i);
            cyc(mk(0, 0, 0, 1, 3'b111, 0, 0, 0,  0, 0, 0, 0, 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
